// File: rtl/ri5cy_instr_ahb_master.sv
// ---------------------------------------------------------------------------
// ri5cy_instr_ahb_master
//
// Purpose:
//   Bridges the RI5CY instruction-fetch port (req/gnt/rvalid) onto AHB-Lite
//   as a single-outstanding, read-only master. Each granted fetch becomes one
//   word-sized NONSEQ SINGLE read. Back-to-back fetches are pipelined so a
//   zero-wait slave sustains one fetch per cycle. Slave ERROR responses are
//   returned to the core as a zero word and latched into a sticky status.
//
// Ports:
//   clk, rst         clock and synchronous active-high reset
//   instr_req_i      core fetch request
//   instr_addr_i     fetch byte address (low two bits ignored)
//   instr_gnt_o      fetch accepted, address phase on the bus this cycle
//   instr_rvalid_o   instr_rdata_o carries a completed fetch this cycle
//   instr_rdata_o    fetched word (zero for errored fetches)
//   haddr_o ..       AHB-Lite master address/control outputs
//   hready_i         AHB bus ready
//   hrdata_i         AHB read data
//   hresp_i          AHB response, 1 = ERROR
//   bus_err_o        sticky fetch-error flag
//   err_addr_o       address of the most recent errored fetch
//   err_clr_i        clears bus_err_o (a simultaneous new error wins)
//
// Only AHB_DATA_WIDTH = 32 is supported.
// ---------------------------------------------------------------------------
module ri5cy_instr_ahb_master #(
    parameter int AHB_ADDR_WIDTH = 32,
    parameter int AHB_DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      instr_req_i,
    input  logic [AHB_ADDR_WIDTH-1:0] instr_addr_i,
    output logic                      instr_gnt_o,
    output logic                      instr_rvalid_o,
    output logic [AHB_DATA_WIDTH-1:0] instr_rdata_o,
    output logic [AHB_ADDR_WIDTH-1:0] haddr_o,
    output logic [1:0]                htrans_o,
    output logic                      hwrite_o,
    output logic [2:0]                hsize_o,
    output logic [2:0]                hburst_o,
    output logic [3:0]                hprot_o,
    output logic [AHB_DATA_WIDTH-1:0] hwdata_o,
    output logic                      hmastlock_o,
    input  logic                      hready_i,
    input  logic [AHB_DATA_WIDTH-1:0] hrdata_i,
    input  logic                      hresp_i,
    output logic                      bus_err_o,
    output logic [AHB_ADDR_WIDTH-1:0] err_addr_o,
    input  logic                      err_clr_i
);

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        ERR2 = 2'd2
    } state_t;

    state_t                    state_q;
    state_t                    state_d;
    logic [AHB_ADDR_WIDTH-1:0] addr_q;
    logic [AHB_ADDR_WIDTH-1:0] err_addr_q;
    logic                      bus_err_q;

    logic                      issue;
    logic                      complete_ok;
    logic                      err_done;

    // Byte-offset bits are meaningless for word fetches.
    logic                      unused_addr_lsbs;
    assign unused_addr_lsbs = &{1'b0, instr_addr_i[1:0]};

    // Read-only word master: control fields never change.
    assign haddr_o     = {instr_addr_i[AHB_ADDR_WIDTH-1:2], 2'b00};
    assign hwrite_o    = 1'b0;
    assign hsize_o     = 3'b010;
    assign hburst_o    = 3'b000;
    assign hprot_o     = 4'b0010;
    assign hwdata_o    = '0;
    assign hmastlock_o = 1'b0;
    assign bus_err_o   = bus_err_q;
    assign err_addr_o  = err_addr_q;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. A plain completion may chain straight into the next
    // data phase; the protocol-violating hready&hresp case ends like ERR2.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (issue) state_d = DATA;
            end
            DATA: begin
                if (hresp_i) begin
                    state_d = hready_i ? IDLE : ERR2;
                end else if (hready_i) begin
                    state_d = issue ? DATA : IDLE;
                end
            end
            ERR2: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output logic. Gating with rst keeps the fetch port quiet while the
    // pending data phase is being dropped, so no orphan gnt or rvalid leaks.
    always_comb begin
        issue       = 1'b0;
        complete_ok = 1'b0;
        err_done    = 1'b0;
        if (!rst) begin
            issue       = instr_req_i & hready_i &
                          ((state_q == IDLE) | ((state_q == DATA) & ~hresp_i));
            complete_ok = (state_q == DATA) & hready_i & ~hresp_i;
            err_done    = (state_q == ERR2) | ((state_q == DATA) & hready_i & hresp_i);
        end
        instr_gnt_o    = issue;
        htrans_o       = issue ? HTRANS_NONSEQ : HTRANS_IDLE;
        instr_rvalid_o = complete_ok | err_done;
        instr_rdata_o  = complete_ok ? hrdata_i : '0;
    end

    // Address of the read in flight and the sticky error status. A new error
    // takes priority over a clear arriving in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q     <= '0;
            bus_err_q  <= 1'b0;
            err_addr_q <= '0;
        end else begin
            if (issue) begin
                addr_q <= haddr_o;
            end
            if (err_done) begin
                bus_err_q  <= 1'b1;
                err_addr_q <= addr_q;
            end else if (err_clr_i) begin
                bus_err_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ri5cy_instr_ahb_master.sv
// ---------------------------------------------------------------------------
// tb_ri5cy_instr_ahb_master
//
// Purpose:
//   Self-checking bench for ri5cy_instr_ahb_master. Directed scenarios cover
//   reset, single fetch, back-to-back fetches, wait states, error responses
//   with the sticky status, and reset during a data phase. A randomized run
//   compares the DUT against a transaction-level model that tracks the queue
//   of outstanding fetch addresses.
// ---------------------------------------------------------------------------
module tb_ri5cy_instr_ahb_master;

    logic        clk;
    logic        rst;
    logic        instr_req_i;
    logic [31:0] instr_addr_i;
    logic        instr_gnt_o;
    logic        instr_rvalid_o;
    logic [31:0] instr_rdata_o;
    logic [31:0] haddr_o;
    logic [1:0]  htrans_o;
    logic        hwrite_o;
    logic [2:0]  hsize_o;
    logic [2:0]  hburst_o;
    logic [3:0]  hprot_o;
    logic [31:0] hwdata_o;
    logic        hmastlock_o;
    logic        hready_i;
    logic [31:0] hrdata_i;
    logic        hresp_i;
    logic        bus_err_o;
    logic [31:0] err_addr_o;
    logic        err_clr_i;

    int checks;
    int failures;

    ri5cy_instr_ahb_master #(
        .AHB_ADDR_WIDTH(32),
        .AHB_DATA_WIDTH(32)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .instr_req_i    (instr_req_i),
        .instr_addr_i   (instr_addr_i),
        .instr_gnt_o    (instr_gnt_o),
        .instr_rvalid_o (instr_rvalid_o),
        .instr_rdata_o  (instr_rdata_o),
        .haddr_o        (haddr_o),
        .htrans_o       (htrans_o),
        .hwrite_o       (hwrite_o),
        .hsize_o        (hsize_o),
        .hburst_o       (hburst_o),
        .hprot_o        (hprot_o),
        .hwdata_o       (hwdata_o),
        .hmastlock_o    (hmastlock_o),
        .hready_i       (hready_i),
        .hrdata_i       (hrdata_i),
        .hresp_i        (hresp_i),
        .bus_err_o      (bus_err_o),
        .err_addr_o     (err_addr_o),
        .err_clr_i      (err_clr_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle's inputs on the falling edge, then let the
    // combinational outputs settle before the caller samples them.
    task automatic applyStimulus(input logic r, input logic req, input logic [31:0] addr,
                                 input logic rdy, input logic resp, input logic [31:0] data,
                                 input logic clr);
        @(negedge clk);
        rst          = r;
        instr_req_i  = req;
        instr_addr_i = addr;
        hready_i     = rdy;
        hresp_i      = resp;
        hrdata_i     = data;
        err_clr_i    = clr;
        #1;
    endtask

    task automatic test_reset();
        applyStimulus(1, 0, 32'h0, 1, 0, 32'h0, 0);
        applyStimulus(1, 0, 32'h0, 1, 0, 32'h0, 0);
        applyStimulus(0, 0, 32'h0, 1, 0, 32'h0, 0);
        checks++; if (instr_gnt_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_gnt: got %b expected 0", instr_gnt_o); end
        checks++; if (htrans_o !== 2'b00) begin failures++; $display("[TB] FAIL reset_htrans: got %b expected 00", htrans_o); end
        checks++; if (instr_rvalid_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_rvalid: got %b expected 0", instr_rvalid_o); end
        checks++; if (bus_err_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_bus_err: got %b expected 0", bus_err_o); end
        checks++; if (err_addr_o !== 32'h0) begin failures++; $display("[TB] FAIL reset_err_addr: got %h expected 0", err_addr_o); end
        checks++; if (instr_rdata_o !== 32'h0) begin failures++; $display("[TB] FAIL reset_rdata: got %h expected 0", instr_rdata_o); end
        checks++; if ({hwrite_o, hsize_o, hburst_o, hprot_o, hmastlock_o} !== {1'b0, 3'b010, 3'b000, 4'b0010, 1'b0}) begin
            failures++; $display("[TB] FAIL const_ctrl: got w=%b sz=%b bu=%b pr=%b lk=%b", hwrite_o, hsize_o, hburst_o, hprot_o, hmastlock_o);
        end
        checks++; if (hwdata_o !== 32'h0) begin failures++; $display("[TB] FAIL const_hwdata: got %h expected 0", hwdata_o); end
    endtask

    task automatic test_single_fetch();
        applyStimulus(0, 1, 32'h1A00_0082, 1, 0, 32'h0, 0);
        checks++; if (instr_gnt_o !== 1'b1) begin failures++; $display("[TB] FAIL single_gnt: got %b expected 1", instr_gnt_o); end
        checks++; if (haddr_o !== 32'h1A00_0080) begin failures++; $display("[TB] FAIL single_haddr: got %h expected 1a000080", haddr_o); end
        checks++; if (htrans_o !== 2'b10) begin failures++; $display("[TB] FAIL single_htrans: got %b expected 10", htrans_o); end
        checks++; if (instr_rvalid_o !== 1'b0) begin failures++; $display("[TB] FAIL single_early_rvalid: got %b expected 0", instr_rvalid_o); end
        applyStimulus(0, 0, 32'h0, 1, 0, 32'hDEAD_BEEF, 0);
        checks++; if (instr_rvalid_o !== 1'b1) begin failures++; $display("[TB] FAIL single_rvalid: got %b expected 1", instr_rvalid_o); end
        checks++; if (instr_rdata_o !== 32'hDEAD_BEEF) begin failures++; $display("[TB] FAIL single_rdata: got %h expected deadbeef", instr_rdata_o); end
        checks++; if (instr_gnt_o !== 1'b0) begin failures++; $display("[TB] FAIL single_no_gnt: got %b expected 0", instr_gnt_o); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] data [5];
        for (int i = 0; i < 5; i++) data[i] = $urandom;
        for (int i = 0; i < 5; i++) begin
            // data[i] is the read data for the fetch granted in cycle i-1
            applyStimulus(0, (i < 4), 32'(4 * i), 1, 0, data[i], 0);
            checks++; if (instr_gnt_o !== (i < 4)) begin failures++; $display("[TB] FAIL b2b_gnt[%0d]: got %b expected %b", i, instr_gnt_o, (i < 4)); end
            checks++; if (htrans_o !== ((i < 4) ? 2'b10 : 2'b00)) begin failures++; $display("[TB] FAIL b2b_htrans[%0d]: got %b", i, htrans_o); end
            if (i < 4) begin
                checks++; if (haddr_o !== 32'(4 * i)) begin failures++; $display("[TB] FAIL b2b_haddr[%0d]: got %h expected %h", i, haddr_o, 32'(4 * i)); end
            end
            checks++; if (instr_rvalid_o !== (i > 0)) begin failures++; $display("[TB] FAIL b2b_rvalid[%0d]: got %b expected %b", i, instr_rvalid_o, (i > 0)); end
            if (i > 0) begin
                checks++; if (instr_rdata_o !== data[i]) begin failures++; $display("[TB] FAIL b2b_rdata[%0d]: got %h expected %h", i, instr_rdata_o, data[i]); end
            end
        end
    endtask

    task automatic test_wait_states();
        logic [31:0] d;
        int          rvalidSeen;
        d          = $urandom;
        rvalidSeen = 0;
        applyStimulus(0, 1, 32'h200, 1, 0, 32'h0, 0);
        checks++; if (instr_gnt_o !== 1'b1) begin failures++; $display("[TB] FAIL wait_first_gnt: got %b expected 1", instr_gnt_o); end
        for (int c = 1; c <= 4; c++) begin
            // hready low in cycles 1-2, request held high throughout the wait
            applyStimulus(0, (c < 3), 32'h204, (c >= 3), 0, (c == 3) ? d : 32'h5A5A_5A5A, 0);
            if (c < 3) begin
                checks++; if (instr_gnt_o !== 1'b0 || htrans_o !== 2'b00) begin failures++; $display("[TB] FAIL wait_no_gnt[%0d]: got gnt=%b htrans=%b expected 0/00", c, instr_gnt_o, htrans_o); end
            end
            if (instr_rvalid_o === 1'b1) begin
                rvalidSeen++;
                checks++; if (c != 3) begin failures++; $display("[TB] FAIL wait_rvalid_cycle: got cycle %0d expected 3", c); end
                checks++; if (instr_rdata_o !== d) begin failures++; $display("[TB] FAIL wait_rdata: got %h expected %h", instr_rdata_o, d); end
            end
        end
        checks++; if (rvalidSeen != 1) begin failures++; $display("[TB] FAIL wait_rvalid_count: got %0d expected 1", rvalidSeen); end
    endtask

    task automatic test_error();
        logic [31:0] d;
        d = $urandom;
        applyStimulus(0, 1, 32'h100, 1, 0, 32'h0, 0);
        checks++; if (instr_gnt_o !== 1'b1) begin failures++; $display("[TB] FAIL err_gnt: got %b expected 1", instr_gnt_o); end
        applyStimulus(0, 1, 32'h104, 0, 1, 32'h1234_5678, 0);
        checks++; if (htrans_o !== 2'b00 || instr_gnt_o !== 1'b0) begin failures++; $display("[TB] FAIL err_cycle1: got htrans=%b gnt=%b expected 00/0", htrans_o, instr_gnt_o); end
        checks++; if (instr_rvalid_o !== 1'b0) begin failures++; $display("[TB] FAIL err_cycle1_rvalid: got %b expected 0", instr_rvalid_o); end
        applyStimulus(0, 1, 32'h104, 1, 1, 32'h1234_5678, 0);
        checks++; if (htrans_o !== 2'b00 || instr_gnt_o !== 1'b0) begin failures++; $display("[TB] FAIL err_cycle2: got htrans=%b gnt=%b expected 00/0", htrans_o, instr_gnt_o); end
        checks++; if (instr_rvalid_o !== 1'b1 || instr_rdata_o !== 32'h0) begin failures++; $display("[TB] FAIL err_rvalid: got rvalid=%b rdata=%h expected 1/0", instr_rvalid_o, instr_rdata_o); end
        checks++; if (bus_err_o !== 1'b0) begin failures++; $display("[TB] FAIL err_early_flag: got %b expected 0", bus_err_o); end
        applyStimulus(0, 1, 32'h300, 1, 0, 32'h0, 0);
        checks++; if (bus_err_o !== 1'b1 || err_addr_o !== 32'h100) begin failures++; $display("[TB] FAIL err_latched: got flag=%b addr=%h expected 1/100", bus_err_o, err_addr_o); end
        checks++; if (instr_gnt_o !== 1'b1) begin failures++; $display("[TB] FAIL err_next_gnt: got %b expected 1", instr_gnt_o); end
        applyStimulus(0, 0, 32'h0, 1, 0, d, 1);
        checks++; if (instr_rvalid_o !== 1'b1 || instr_rdata_o !== d) begin failures++; $display("[TB] FAIL err_followup: got rvalid=%b rdata=%h expected 1/%h", instr_rvalid_o, instr_rdata_o, d); end
        checks++; if (bus_err_o !== 1'b1) begin failures++; $display("[TB] FAIL err_clr_early: got %b expected 1", bus_err_o); end
        applyStimulus(0, 1, 32'h104, 1, 0, 32'h0, 0);
        checks++; if (bus_err_o !== 1'b0 || err_addr_o !== 32'h100) begin failures++; $display("[TB] FAIL err_cleared: got flag=%b addr=%h expected 0/100", bus_err_o, err_addr_o); end
        // second error with a clear pulsed during the completing cycle
        applyStimulus(0, 0, 32'h0, 0, 1, 32'h0, 0);
        applyStimulus(0, 0, 32'h0, 1, 1, 32'h0, 1);
        applyStimulus(0, 0, 32'h0, 1, 0, 32'h0, 1);
        checks++; if (bus_err_o !== 1'b1 || err_addr_o !== 32'h104) begin failures++; $display("[TB] FAIL err_set_wins: got flag=%b addr=%h expected 1/104", bus_err_o, err_addr_o); end
        applyStimulus(0, 0, 32'h0, 1, 0, 32'h0, 0);
        checks++; if (bus_err_o !== 1'b0) begin failures++; $display("[TB] FAIL err_clear2: got %b expected 0", bus_err_o); end
    endtask

    task automatic test_reset_mid_transfer();
        logic [31:0] d;
        d = $urandom;
        applyStimulus(0, 1, 32'h400, 1, 0, 32'h0, 0);
        checks++; if (instr_gnt_o !== 1'b1) begin failures++; $display("[TB] FAIL rstmid_gnt: got %b expected 1", instr_gnt_o); end
        applyStimulus(1, 0, 32'h0, 0, 0, 32'h0, 0);
        applyStimulus(0, 0, 32'h0, 1, 0, 32'hCAFE_F00D, 0);
        checks++; if (instr_rvalid_o !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_rvalid: got %b expected 0", instr_rvalid_o); end
        checks++; if (htrans_o !== 2'b00 || instr_gnt_o !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_idle: got htrans=%b gnt=%b expected 00/0", htrans_o, instr_gnt_o); end
        applyStimulus(0, 1, 32'h408, 1, 0, 32'h0, 0);
        checks++; if (instr_gnt_o !== 1'b1 || haddr_o !== 32'h408) begin failures++; $display("[TB] FAIL rstmid_refetch: got gnt=%b haddr=%h expected 1/408", instr_gnt_o, haddr_o); end
        applyStimulus(0, 0, 32'h0, 1, 0, d, 0);
        checks++; if (instr_rvalid_o !== 1'b1 || instr_rdata_o !== d) begin failures++; $display("[TB] FAIL rstmid_complete: got rvalid=%b rdata=%h expected 1/%h", instr_rvalid_o, instr_rdata_o, d); end
    endtask

    // Randomized run against a transaction model: a queue of fetch addresses
    // whose data phase is open, plus the tail of a two-cycle ERROR response.
    task automatic test_random();
        logic [31:0] outstanding [$];
        logic        errTail;
        logic [31:0] errTailAddr;
        logic        expBusErr;
        logic [31:0] expErrAddr;
        int          gntCount;
        int          rvalidCount;
        logic        req, rdy, resp, clr;
        logic [31:0] addr, data;
        logic        expGnt, completeOk, errEnd, expRvalid;
        logic [31:0] expRdata;
        int          pick;

        applyStimulus(1, 0, 32'h0, 1, 0, 32'h0, 0);
        errTail     = 1'b0;
        errTailAddr = 32'h0;
        expBusErr   = 1'b0;
        expErrAddr  = 32'h0;
        gntCount    = 0;
        rvalidCount = 0;

        for (int cyc = 0; cyc < 600; cyc++) begin
            req  = (cyc < 590) && ($urandom_range(3) != 0);
            addr = $urandom;
            data = $urandom;
            clr  = ($urandom_range(15) == 0);
            if (errTail) begin
                rdy = 1'b1; resp = 1'b1;
            end else if (outstanding.size() != 0) begin
                pick = (cyc < 590) ? int'($urandom_range(99)) : 0;
                if (pick < 60)      begin rdy = 1'b1; resp = 1'b0; end
                else if (pick < 85) begin rdy = 1'b0; resp = 1'b0; end
                else if (pick < 95) begin rdy = 1'b0; resp = 1'b1; end
                else                begin rdy = 1'b1; resp = 1'b1; end
            end else begin
                rdy  = ($urandom_range(7) != 0);
                resp = 1'b0;
            end

            applyStimulus(0, req, addr, rdy, resp, data, clr);

            expGnt     = req && rdy && ((outstanding.size() == 0 && !errTail) ||
                                        (outstanding.size() != 0 && !resp));
            completeOk = (outstanding.size() != 0) && rdy && !resp;
            errEnd     = errTail || ((outstanding.size() != 0) && rdy && resp);
            expRvalid  = completeOk || errEnd;
            expRdata   = completeOk ? data : 32'h0;

            checks++; if (instr_gnt_o !== expGnt) begin failures++; $display("[TB] FAIL rand_gnt@%0d: got %b expected %b", cyc, instr_gnt_o, expGnt); end
            checks++; if (htrans_o !== (expGnt ? 2'b10 : 2'b00)) begin failures++; $display("[TB] FAIL rand_htrans@%0d: got %b expected %b", cyc, htrans_o, (expGnt ? 2'b10 : 2'b00)); end
            checks++; if (haddr_o !== (addr & 32'hFFFF_FFFC)) begin failures++; $display("[TB] FAIL rand_haddr@%0d: got %h expected %h", cyc, haddr_o, addr & 32'hFFFF_FFFC); end
            checks++; if (instr_rvalid_o !== expRvalid) begin failures++; $display("[TB] FAIL rand_rvalid@%0d: got %b expected %b", cyc, instr_rvalid_o, expRvalid); end
            checks++; if (instr_rdata_o !== expRdata) begin failures++; $display("[TB] FAIL rand_rdata@%0d: got %h expected %h", cyc, instr_rdata_o, expRdata); end
            checks++; if (bus_err_o !== expBusErr) begin failures++; $display("[TB] FAIL rand_bus_err@%0d: got %b expected %b", cyc, bus_err_o, expBusErr); end
            checks++; if (err_addr_o !== expErrAddr) begin failures++; $display("[TB] FAIL rand_err_addr@%0d: got %h expected %h", cyc, err_addr_o, expErrAddr); end

            if (instr_gnt_o === 1'b1) gntCount++;
            if (instr_rvalid_o === 1'b1) rvalidCount++;

            // advance the model to the state after this clock edge
            if (errEnd) begin
                expBusErr  = 1'b1;
                expErrAddr = errTail ? errTailAddr : outstanding[0];
            end else if (clr) begin
                expBusErr = 1'b0;
            end
            if (errTail) begin
                errTail = 1'b0;
            end else if (outstanding.size() != 0 && !rdy && resp) begin
                errTail     = 1'b1;
                errTailAddr = outstanding.pop_front();
            end else if (outstanding.size() != 0 && rdy) begin
                void'(outstanding.pop_front());
            end
            if (expGnt) outstanding.push_back(addr & 32'hFFFF_FFFC);
        end

        checks++; if (outstanding.size() != 0 || errTail) begin failures++; $display("[TB] FAIL rand_drain: got %0d pending expected 0", outstanding.size()); end
        checks++; if (gntCount != rvalidCount) begin failures++; $display("[TB] FAIL rand_gnt_rvalid_balance: got gnt=%0d rvalid=%0d expected equal", gntCount, rvalidCount); end
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        rst          = 1'b1;
        instr_req_i  = 1'b0;
        instr_addr_i = 32'h0;
        hready_i     = 1'b1;
        hresp_i      = 1'b0;
        hrdata_i     = 32'h0;
        err_clr_i    = 1'b0;

        test_reset();
        test_single_fetch();
        test_back_to_back();
        test_wait_states();
        test_error();
        test_reset_mid_transfer();
        test_random();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
